routing_unit_adaptive: RTL and testbench

ROUTING_UNIT_ADAPTIVE -- requirements
Module: routing_unit_adaptive

---
 rtl/routing_unit_adaptive_pkg.sv | 33 +++
 rtl/route_xy_calc.sv | 39 +++
 rtl/routing_unit_adaptive.sv | 158 +++++++++++++++
 tb/tb_routing_unit_adaptive.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/routing_unit_adaptive_pkg.sv
// Shared router constants: port indices, flit width, region codes,
// routing-mode encodings and the routing FSM state type.
package routing_unit_adaptive_pkg;

    localparam int NPORT         = 5;
    localparam int TAM_FLIT      = 16;
    localparam int ROUTERCONTROL = 2;

    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;

    localparam logic [ROUTERCONTROL-1:0] INVALID_REGION = 2'b00;
    localparam logic [ROUTERCONTROL-1:0] VALID_REGION   = 2'b01;

    localparam int MODE_XY = 0;
    localparam int MODE_YX = 1;
    localparam int MODE_WF = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WAIT,
        S_DONE
    } state_t;

    function automatic logic [NPORT-1:0] port_oh(input int idx);
        return NPORT'(1) << idx;
    endfunction

endpackage

// File: rtl/route_xy_calc.sv
// Combinational dimension-order route: XY or YX (YFIRST=1).
// Ports: dest (header flit, X upper / Y lower), port (one-hot output port).
module route_xy_calc
    import routing_unit_adaptive_pkg::*;
#(
    parameter logic [31:0] ADDRESS    = 32'h0000,
    parameter int          FLIT_WIDTH = TAM_FLIT,
    parameter bit          YFIRST     = 1'b0
) (
    input  logic [FLIT_WIDTH-1:0] dest,
    output logic [NPORT-1:0]      port
);

    localparam int HALF = FLIT_WIDTH / 2;
    localparam logic [HALF-1:0] LX = ADDRESS[FLIT_WIDTH-1:HALF];
    localparam logic [HALF-1:0] LY = ADDRESS[HALF-1:0];

    logic [HALF-1:0] dx;
    logic [HALF-1:0] dy;

    assign dx = dest[FLIT_WIDTH-1:HALF];
    assign dy = dest[HALF-1:0];

    always_comb begin
        port = port_oh(LOCAL);
        if (YFIRST) begin
            if (dy < LY)      port = port_oh(SOUTH);
            else if (dy > LY) port = port_oh(NORTH);
            else if (dx > LX) port = port_oh(EAST);
            else if (dx < LX) port = port_oh(WEST);
        end else begin
            if (dx > LX)      port = port_oh(EAST);
            else if (dx < LX) port = port_oh(WEST);
            else if (dy < LY) port = port_oh(SOUTH);
            else if (dy > LY) port = port_oh(NORTH);
        end
    end

endmodule

// File: rtl/routing_unit_adaptive.sv
// Router output-port selection: XY, YX or west-first adaptive with timeout.
// Ports: i_clk, i_rst (sync, active high), i_req/i_dest request,
// i_portBusy per-port busy; o_ack, o_outputPort (one-hot), o_find region.
module routing_unit_adaptive
    import routing_unit_adaptive_pkg::*;
#(
    parameter logic [31:0] ADDRESS    = 32'h0000,
    parameter int          FLIT_WIDTH = TAM_FLIT,
    parameter int          MODE       = MODE_XY,
    parameter int          TIMEOUT    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req,
    input  logic [FLIT_WIDTH-1:0]    i_dest,
    input  logic [NPORT-1:0]         i_portBusy,
    output logic                     o_ack,
    output logic [NPORT-1:0]         o_outputPort,
    output logic [ROUTERCONTROL-1:0] o_find
);

    localparam int HALF = FLIT_WIDTH / 2;
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [HALF-1:0] LX = ADDRESS[FLIT_WIDTH-1:HALF];
    localparam logic [HALF-1:0] LY = ADDRESS[HALF-1:0];

    state_t                state;
    state_t                state_nx;
    logic [FLIT_WIDTH-1:0] dest_q;
    logic [CW-1:0]         wcnt;
    logic [CW-1:0]         wcnt_nx;
    logic [CW-1:0]         wnext;
    logic [NPORT-1:0]      sel_q;
    logic [NPORT-1:0]      sel_nx;
    logic [NPORT-1:0]      dor_port;
    logic [NPORT-1:0]      xy_port;
    logic [NPORT-1:0]      adapt;
    logic                  adapt_ok;
    logic                  hold;
    logic [HALF-1:0]       dx;
    logic [HALF-1:0]       dy;
    logic                  unused_busy;

    assign dx = dest_q[FLIT_WIDTH-1:HALF];
    assign dy = dest_q[HALF-1:0];
    assign unused_busy = ^{i_portBusy[WEST], i_portBusy[LOCAL]};

    route_xy_calc #(
        .ADDRESS   (ADDRESS),
        .FLIT_WIDTH(FLIT_WIDTH),
        .YFIRST    (MODE == MODE_YX)
    ) u_dor (
        .dest(dest_q),
        .port(dor_port)
    );

    // XY fallback once the adaptive wait expires
    route_xy_calc #(
        .ADDRESS   (ADDRESS),
        .FLIT_WIDTH(FLIT_WIDTH),
        .YFIRST    (1'b0)
    ) u_fallback (
        .dest(dest_q),
        .port(xy_port)
    );

    // West-first: westward and local are fixed, others pick a free port
    always_comb begin
        adapt    = '0;
        adapt_ok = 1'b1;
        if (dx < LX)
            adapt = port_oh(WEST);
        else if (dx == LX && dy == LY)
            adapt = port_oh(LOCAL);
        else if (dx > LX && !i_portBusy[EAST])
            adapt = port_oh(EAST);
        else if (dy > LY && !i_portBusy[NORTH])
            adapt = port_oh(NORTH);
        else if (dy < LY && !i_portBusy[SOUTH])
            adapt = port_oh(SOUTH);
        else
            adapt_ok = 1'b0;
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        sel_nx   = sel_q;
        wnext    = wcnt + 1'b1;
        unique case (state)
            S_IDLE: begin
                wcnt_nx = '0;
                sel_nx  = '0;
                if (i_req) state_nx = S_CALC;
            end
            S_CALC: begin
                if (!i_req) begin
                    state_nx = S_IDLE;
                    wcnt_nx  = '0;
                end else if (MODE != MODE_WF) begin
                    sel_nx   = dor_port;
                    state_nx = S_DONE;
                end else if (adapt_ok) begin
                    sel_nx   = adapt;
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_req) begin
                    state_nx = S_IDLE;
                    wcnt_nx  = '0;
                end else if (adapt_ok) begin
                    sel_nx   = adapt;
                    state_nx = S_DONE;
                end else if (wnext == CW'(TIMEOUT)) begin
                    wcnt_nx  = wnext;
                    sel_nx   = xy_port;
                    state_nx = S_DONE;
                end else begin
                    wcnt_nx  = wnext;
                end
            end
            S_DONE: begin
                if (!i_req) begin
                    state_nx = S_IDLE;
                    wcnt_nx  = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs present the held route only while the request is kept up
    assign hold = (state == S_DONE) && i_req;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            dest_q       <= '0;
            wcnt         <= '0;
            sel_q        <= '0;
            o_ack        <= 1'b0;
            o_outputPort <= '0;
            o_find       <= INVALID_REGION;
        end else begin
            state        <= state_nx;
            wcnt         <= wcnt_nx;
            sel_q        <= sel_nx;
            if (state == S_IDLE && i_req) dest_q <= i_dest;
            o_ack        <= hold;
            o_outputPort <= hold ? sel_q : '0;
            o_find       <= hold ? VALID_REGION : INVALID_REGION;
        end
    end

endmodule

// File: tb/tb_routing_unit_adaptive.sv
// Directed bench for routing_unit_adaptive: one instance per MODE,
// router at 0x0101, TIMEOUT 8.
module tb_routing_unit_adaptive;

    localparam logic [4:0] PE = 5'b00001;
    localparam logic [4:0] PW = 5'b00010;
    localparam logic [4:0] PN = 5'b00100;
    localparam logic [4:0] PS = 5'b01000;
    localparam logic [4:0] PL = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] dest;
    logic [4:0]  busy;
    logic        ack  [3];
    logic [4:0]  port [3];
    logic [1:0]  find [3];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    routing_unit_adaptive #(
        .ADDRESS(32'h0101), .FLIT_WIDTH(16), .MODE(0), .TIMEOUT(8)
    ) u_xy (
        .i_clk(clk), .i_rst(rst), .i_req(req[0]), .i_dest(dest),
        .i_portBusy(busy), .o_ack(ack[0]), .o_outputPort(port[0]),
        .o_find(find[0])
    );

    routing_unit_adaptive #(
        .ADDRESS(32'h0101), .FLIT_WIDTH(16), .MODE(1), .TIMEOUT(8)
    ) u_yx (
        .i_clk(clk), .i_rst(rst), .i_req(req[1]), .i_dest(dest),
        .i_portBusy(busy), .o_ack(ack[1]), .o_outputPort(port[1]),
        .o_find(find[1])
    );

    routing_unit_adaptive #(
        .ADDRESS(32'h0101), .FLIT_WIDTH(16), .MODE(2), .TIMEOUT(8)
    ) u_wf (
        .i_clk(clk), .i_rst(rst), .i_req(req[2]), .i_dest(dest),
        .i_portBusy(busy), .o_ack(ack[2]), .o_outputPort(port[2]),
        .o_find(find[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int m, input string tag);
        check({tag, "_ack"}, 32'(ack[m]), 0);
        check({tag, "_port"}, 32'(port[m]), 0);
        check({tag, "_find"}, 32'(find[m]), 0);
    endtask

    // Raise req on instance m and measure the edge index (0 = the
    // req-sampling edge) after which o_ack first reads 1.
    task automatic do_req(input int m, input logic [15:0] d,
                          input logic [4:0] b0, input int rel,
                          input logic [4:0] b1, input logic [4:0] exp_port,
                          input int exp_edge, input string tag);
        int  edge_n;
        bit  got;
        edge_n = -1;
        got    = 1'b0;
        dest   = d;
        busy   = b0;
        req[m] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            edge_n = i;
            if (i == rel) busy = b1;
            if (ack[m]) got = 1'b1;
        end
        check({tag, "_edge"}, 32'(edge_n), 32'(exp_edge));
        check({tag, "_port"}, 32'(port[m]), 32'(exp_port));
        check({tag, "_find"}, 32'(find[m]), 32'h1);
        req[m] = 1'b0;
        busy   = '0;
        tick();
        check_idle(m, {tag, "_rel"});
        tick();
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        dest = 16'h0000;
        busy = '0;
        tick();
        tick();
        for (int m = 0; m < 3; m++)
            check_idle(m, $sformatf("reset%0d", m));
        rst = 1'b0;
        tick();

        do_req(0, 16'h0302, 5'h00, -1, 5'h00, PE, 2, "xy_east");
        do_req(0, 16'h0302, 5'h1f, -1, 5'h00, PE, 2, "xy_busy_ignored");
        do_req(0, 16'h0001, 5'h00, -1, 5'h00, PW, 2, "xy_west");
        do_req(0, 16'h0100, 5'h00, -1, 5'h00, PS, 2, "xy_south");
        do_req(0, 16'h0103, 5'h00, -1, 5'h00, PN, 2, "xy_north");
        do_req(0, 16'h0101, 5'h00, -1, 5'h00, PL, 2, "xy_local");

        do_req(1, 16'h0302, 5'h00, -1, 5'h00, PN, 2, "yx_north");
        do_req(1, 16'h0100, 5'h00, -1, 5'h00, PS, 2, "yx_south");
        do_req(1, 16'h0101, 5'h00, -1, 5'h00, PL, 2, "yx_local");
        do_req(1, 16'h0001, 5'h00, -1, 5'h00, PW, 2, "yx_west");

        do_req(2, 16'h0302, 5'h00, -1, 5'h00, PE, 2, "wf_east");
        do_req(2, 16'h0302, PE, -1, 5'h00, PN, 2, "wf_north_alt");
        do_req(2, 16'h0302, PE | PN, 4, PN, PE, 6, "wf_wait3");
        do_req(2, 16'h0302, PE | PN, -1, 5'h00, PE, 10, "wf_timeout");
        do_req(2, 16'h0001, PW, -1, 5'h00, PW, 2, "wf_west");
        do_req(2, 16'h0300, PE, -1, 5'h00, PS, 2, "wf_south_alt");
        do_req(2, 16'h0101, 5'h1f, -1, 5'h00, PL, 2, "wf_local");

        // Drop the request while waiting: no acknowledge may follow
        dest   = 16'h0302;
        busy   = PE | PN;
        req[2] = 1'b1;
        tick();
        tick();
        tick();
        check_idle(2, "abort_wait");
        req[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle(2, $sformatf("abort_after%0d", i));
        end
        do_req(2, 16'h0302, 5'h00, -1, 5'h00, PE, 2, "wf_after_abort");

        // Reset while holding a route
        dest   = 16'h0302;
        busy   = '0;
        req[0] = 1'b1;
        tick();
        tick();
        tick();
        check("rst_pre_ack", 32'(ack[0]), 1);
        check("rst_pre_port", 32'(port[0]), 32'(PE));
        rst = 1'b1;
        tick();
        check_idle(0, "rst_done");
        rst    = 1'b0;
        req[0] = 1'b0;
        tick();
        tick();
        check_idle(0, "rst_settled");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
